// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM stage.
// Data requests win unless fetch has been starved STARVE_LIMIT times in a row.
module mem_port_arbiter #(
   parameter int ADDR_W       = 9,
   parameter int WAIT_STATES  = 1,
   parameter int STARVE_LIMIT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_ready,
   output logic [31:0]       if_rdata,
   input  logic              dm_req,
   input  logic              dm_write,
   input  logic [31:0]       dm_addr,
   input  logic [31:0]       dm_wdata,
   input  logic [1:0]        dm_size,
   output logic              dm_ready,
   output logic [31:0]       dm_rdata,
   output logic              mem_en,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [1:0]        mem_size,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);
   localparam logic [2:0] LIMIT     = 3'(STARVE_LIMIT);

   state_t     state_reg;
   logic [2:0] wait_cnt_reg;
   logic [2:0] starve_cnt_reg;
   logic       owner_reg;      // 1 = data port owns the current access
   logic       grant_data;

   // Upper address bits are deliberately dropped (addresses wrap).
   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr[31:ADDR_W], dm_addr[31:ADDR_W]};

   assign grant_data = dm_req && !(if_req && (starve_cnt_reg == LIMIT));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         wait_cnt_reg   <= '0;
         starve_cnt_reg <= '0;
         owner_reg      <= 1'b0;
         if_ready       <= 1'b0;
         dm_ready       <= 1'b0;
         if_rdata       <= '0;
         dm_rdata       <= '0;
         mem_en         <= 1'b0;
         mem_rw         <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
         mem_size       <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (if_req || dm_req) begin
                  state_reg    <= BUSY;
                  wait_cnt_reg <= WAIT_INIT;
                  owner_reg    <= grant_data;
                  mem_en       <= 1'b1;
                  if (grant_data) begin
                     mem_rw    <= dm_write;
                     mem_addr  <= dm_addr[ADDR_W-1:0];
                     mem_wdata <= dm_wdata;
                     mem_size  <= dm_size;
                     // Data only wins a contested grant below the limit, so no overflow here.
                     starve_cnt_reg <= if_req ? starve_cnt_reg + 3'd1 : 3'd0;
                  end else begin
                     mem_rw         <= 1'b0;
                     mem_addr       <= if_addr[ADDR_W-1:0];
                     mem_wdata      <= '0;
                     mem_size       <= 2'b10;
                     starve_cnt_reg <= 3'd0;
                  end
               end
            end
            BUSY: begin
               if (wait_cnt_reg == 3'd0) begin
                  if (!mem_rw) begin
                     if (owner_reg) dm_rdata <= mem_rdata;
                     else           if_rdata <= mem_rdata;
                  end
                  dm_ready  <= owner_reg;
                  if_ready  <= !owner_reg;
                  state_reg <= RESP;
                  mem_en    <= 1'b0;
                  mem_rw    <= 1'b0;
                  mem_addr  <= '0;
                  mem_wdata <= '0;
                  mem_size  <= '0;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg - 3'd1;
               end
            end
            RESP: begin
               // Bubble cycle: requesters drop or renew before the next arbitration.
               if_ready  <= 1'b0;
               dm_ready  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (WAIT_STATES 1, 3, 0) with simple word memories.
module tb_mem_port_arbiter;

   localparam int N = 3;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        reset     [N];
   logic        if_req    [N];
   logic [31:0] if_addr   [N];
   logic        if_ready  [N];
   logic [31:0] if_rdata  [N];
   logic        dm_req    [N];
   logic        dm_write  [N];
   logic [31:0] dm_addr   [N];
   logic [31:0] dm_wdata  [N];
   logic [1:0]  dm_size   [N];
   logic        dm_ready  [N];
   logic [31:0] dm_rdata  [N];
   logic        mem_en    [N];
   logic        mem_rw    [N];
   logic [8:0]  mem_addr  [N];
   logic [31:0] mem_wdata [N];
   logic [1:0]  mem_size  [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_dut
      localparam int WS = (gi == 0) ? 1 : (gi == 1) ? 3 : 0;
      logic [31:0] ram [128];
      logic [31:0] rd;
      int          rdy_cnt = 0;

      mem_port_arbiter #(.ADDR_W(9), .WAIT_STATES(WS), .STARVE_LIMIT(2)) dut (
         .clk(clk), .reset(reset[gi]),
         .if_req(if_req[gi]), .if_addr(if_addr[gi]), .if_ready(if_ready[gi]), .if_rdata(if_rdata[gi]),
         .dm_req(dm_req[gi]), .dm_write(dm_write[gi]), .dm_addr(dm_addr[gi]), .dm_wdata(dm_wdata[gi]),
         .dm_size(dm_size[gi]), .dm_ready(dm_ready[gi]), .dm_rdata(dm_rdata[gi]),
         .mem_en(mem_en[gi]), .mem_rw(mem_rw[gi]), .mem_addr(mem_addr[gi]), .mem_wdata(mem_wdata[gi]),
         .mem_size(mem_size[gi]), .mem_rdata(rd)
      );

      assign rd = (mem_en[gi] && !mem_rw[gi]) ? ram[mem_addr[gi][8:2]] : 32'h0;
      always @(posedge clk) if (mem_en[gi] && mem_rw[gi]) ram[mem_addr[gi][8:2]] <= mem_wdata[gi];
      always @(negedge clk) if (if_ready[gi] || dm_ready[gi]) rdy_cnt <= rdy_cnt + 1;

      initial begin
         for (int i = 0; i < 128; i++) ram[i] = 32'h0;
         ram[1] = 32'hA5A5_0004;
         ram[2] = 32'h0050_0093;
         ram[8] = 32'h1111_2222;
      end
   end

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   typedef struct {
      bit          is_data;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic [31:0] exp_rdata;
      logic [8:0]  exp_maddr;
   } vec_t;

   typedef struct {
      bit          is_data;
      int          exp_cyc;
      logic [31:0] exp_rdata;
      logic [8:0]  exp_maddr;
      bit          exp_rw;
      logic [1:0]  exp_size;
   } exp_t;

   exp_t sb[$];

   // Scoreboard monitor for instance 0 (WAIT_STATES = 1, two mem_en cycles per access).
   initial begin
      int          en_cnt = 0;
      logic [8:0]  l_addr = '0;
      logic        l_rw   = 1'b0;
      logic [1:0]  l_size = '0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (mem_en[0]) begin
            en_cnt++;
            l_addr = mem_addr[0];
            l_rw   = mem_rw[0];
            l_size = mem_size[0];
         end
         if (if_ready[0] || dm_ready[0]) begin
            if (sb.size() == 0) begin
               chk("unexpected_ready", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               chk("owner_is_data", 32'(dm_ready[0]), 32'(e.is_data));
               chk("both_ready", 32'(if_ready[0] & dm_ready[0]), 32'h0);
               chk("ready_cycle", 32'(cyc), 32'(e.exp_cyc));
               chk("rdata", e.is_data ? dm_rdata[0] : if_rdata[0], e.exp_rdata);
               chk("mem_en_cycles", 32'(en_cnt), 32'd2);
               chk("mem_addr", 32'(l_addr), 32'(e.exp_maddr));
               chk("mem_rw", 32'(l_rw), 32'(e.exp_rw));
               chk("mem_size", 32'(l_size), 32'(e.exp_size));
               $display("[TB] txn %s addr=%h rdata=%h cycle=%0d", e.is_data ? "data" : "fetch",
                        l_addr, e.is_data ? dm_rdata[0] : if_rdata[0], cyc);
            end
            en_cnt = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic wait_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Waits for instance-0 ready of one port, then drops that request in the following IDLE cycle.
   task automatic wait_ready(input bit data);
      int n = 0;
      while (n < 40) begin
         @(negedge clk);
         if (data ? dm_ready[0] : if_ready[0]) break;
         n++;
      end
      if (n >= 40) chk(data ? "dm_ready_timeout" : "if_ready_timeout", 32'h0, 32'h1);
      @(posedge clk);
      #1;
      if (data) dm_req[0] = 1'b0;
      else      if_req[0] = 1'b0;
   endtask

   task automatic push(input bit d, input int c, input logic [31:0] r, input logic [8:0] a,
                       input bit w, input logic [1:0] s);
      exp_t e;
      e.is_data = d; e.exp_cyc = c; e.exp_rdata = r; e.exp_maddr = a; e.exp_rw = w; e.exp_size = s;
      sb.push_back(e);
   endtask

   vec_t vecs[7];

   initial begin
      int c0;
      int r0;

      vecs[0] = '{0, 0, 32'h0000_0008, 32'h0,         2'b10, 32'h0050_0093, 9'h008};
      vecs[1] = '{1, 0, 32'h0000_0020, 32'h0,         2'b10, 32'h1111_2222, 9'h020};
      vecs[2] = '{1, 1, 32'h0000_0024, 32'hDEAD_BEEF, 2'b10, 32'h1111_2222, 9'h024};
      vecs[3] = '{1, 0, 32'h0000_0024, 32'h0,         2'b10, 32'hDEAD_BEEF, 9'h024};
      vecs[4] = '{0, 0, 32'h0000_0208, 32'h0,         2'b10, 32'h0050_0093, 9'h008};
      vecs[5] = '{1, 1, 32'h0000_01FC, 32'h0BAD_F00D, 2'b01, 32'hDEAD_BEEF, 9'h1FC};
      vecs[6] = '{1, 0, 32'h0000_03FC, 32'h0,         2'b00, 32'h0BAD_F00D, 9'h1FC};

      for (int k = 0; k < N; k++) begin
         reset[k] = 1'b1; if_req[k] = 1'b0; if_addr[k] = '0; dm_req[k] = 1'b0;
         dm_write[k] = 1'b0; dm_addr[k] = '0; dm_wdata[k] = '0; dm_size[k] = '0;
      end
      repeat (2) @(negedge clk);
      chk("rst_if_ready", 32'(if_ready[0]), 32'h0);
      chk("rst_dm_ready", 32'(dm_ready[0]), 32'h0);
      chk("rst_if_rdata", if_rdata[0], 32'h0);
      chk("rst_dm_rdata", dm_rdata[0], 32'h0);
      chk("rst_mem_ctl", {29'h0, mem_en[0], mem_rw[0], 1'b0}, 32'h0);
      chk("rst_mem_addr", 32'(mem_addr[0]), 32'h0);
      chk("rst_mem_wdata", mem_wdata[0], 32'h0);
      chk("rst_mem_size", 32'(mem_size[0]), 32'h0);
      chk("rst_starve", 32'(g_dut[0].dut.starve_cnt_reg), 32'h0);
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) reset[k] = 1'b0;
      @(posedge clk);
      #1;

      // Single, isolated accesses on instance 0.
      for (int v = 0; v < 7; v++) begin
         if (vecs[v].is_data) begin
            dm_req[0] = 1'b1; dm_write[0] = vecs[v].wr; dm_addr[0] = vecs[v].addr;
            dm_wdata[0] = vecs[v].wdata; dm_size[0] = vecs[v].size;
         end else begin
            if_req[0] = 1'b1; if_addr[0] = vecs[v].addr;
         end
         push(vecs[v].is_data, cyc + 3, vecs[v].exp_rdata, vecs[v].exp_maddr, vecs[v].wr, vecs[v].size);
         wait_ready(vecs[v].is_data);
         dm_write[0] = 1'b0;
      end

      // Simultaneous requests: data first, fetch in the IDLE after RESP.
      c0 = cyc;
      dm_req[0] = 1'b1; dm_write[0] = 1'b0; dm_addr[0] = 32'h20; dm_size[0] = 2'b10;
      if_req[0] = 1'b1; if_addr[0] = 32'h8;
      push(1, c0 + 3, 32'h1111_2222, 9'h020, 0, 2'b10);
      push(0, c0 + 7, 32'h0050_0093, 9'h008, 0, 2'b10);
      wait_ready(1);
      wait_ready(0);
      @(posedge clk);
      #1;

      // Starvation guard: fetch held, data continuously renewed.
      c0 = cyc;
      dm_req[0] = 1'b1; if_req[0] = 1'b1;
      push(1, c0 + 3,  32'h1111_2222, 9'h020, 0, 2'b10);
      push(1, c0 + 7,  32'h1111_2222, 9'h020, 0, 2'b10);
      push(0, c0 + 11, 32'h0050_0093, 9'h008, 0, 2'b10);
      push(1, c0 + 15, 32'h1111_2222, 9'h020, 0, 2'b10);
      push(0, c0 + 19, 32'h0050_0093, 9'h008, 0, 2'b10);
      wait_to(c0 + 5);
      chk("starve_at_limit", 32'(g_dut[0].dut.starve_cnt_reg), 32'd2);
      wait_to(c0 + 9);
      chk("starve_after_fetch", 32'(g_dut[0].dut.starve_cnt_reg), 32'd0);
      wait_to(c0 + 13);
      chk("starve_restart", 32'(g_dut[0].dut.starve_cnt_reg), 32'd1);
      wait_to(c0 + 16);
      dm_req[0] = 1'b0;
      wait_to(c0 + 20);
      if_req[0] = 1'b0;
      wait_to(c0 + 24);
      chk("scoreboard_empty", 32'(sb.size()), 32'h0);

      // Reset in the second BUSY cycle of a WAIT_STATES=3 access.
      c0 = cyc;
      if_req[1] = 1'b1; if_addr[1] = 32'h8;
      wait_to(c0 + 2);
      chk("rm_busy_before", 32'(mem_en[1]), 32'h1);
      r0 = g_dut[1].rdy_cnt;
      reset[1] = 1'b1;
      #1;
      chk("rm_mem_en_drop", 32'(mem_en[1]), 32'h0);
      chk("rm_outputs_zero", {if_rdata[1] | dm_rdata[1] | mem_wdata[1]}, 32'h0);
      chk("rm_ctl_zero", {21'h0, if_ready[1], dm_ready[1], mem_rw[1], mem_addr[1]} | 32'(mem_size[1]), 32'h0);
      wait_to(c0 + 4);
      reset[1] = 1'b0;
      c0 = cyc;
      wait_to(c0 + 1);
      chk("rm_regrant", 32'(mem_en[1]), 32'h1);
      wait_to(c0 + 4);
      chk("rm_no_ready_lost", 32'(g_dut[1].rdy_cnt), 32'(r0));
      chk("rm_ready_early", 32'(if_ready[1]), 32'h0);
      wait_to(c0 + 5);
      chk("rm_ready_latency", 32'(if_ready[1]), 32'h1);
      chk("rm_rdata", if_rdata[1], 32'h0050_0093);
      wait_to(c0 + 6);
      if_req[1] = 1'b0;
      $display("[TB] txn reset-mid-access fetch addr=008 rdata=%h cycle=%0d", if_rdata[1], cyc);

      // WAIT_STATES=0 fetch with address wrap, then a back-to-back repeat.
      c0 = cyc;
      if_req[2] = 1'b1; if_addr[2] = 32'h204;
      wait_to(c0 + 1);
      chk("z_mem_en", 32'(mem_en[2]), 32'h1);
      chk("z_mem_addr_wrap", 32'(mem_addr[2]), 32'h004);
      chk("z_mem_size", 32'(mem_size[2]), 32'h2);
      wait_to(c0 + 2);
      chk("z_mem_en_one_cycle", 32'(mem_en[2]), 32'h0);
      chk("z_if_ready", 32'(if_ready[2]), 32'h1);
      chk("z_if_rdata", if_rdata[2], 32'hA5A5_0004);
      wait_to(c0 + 3);
      chk("z_ready_pulse", 32'(if_ready[2]), 32'h0);
      chk("z_idle_gap", 32'(mem_en[2]), 32'h0);
      wait_to(c0 + 4);
      chk("z_b2b_mem_en", 32'(mem_en[2]), 32'h1);
      wait_to(c0 + 5);
      chk("z_b2b_ready", 32'(if_ready[2]), 32'h1);
      wait_to(c0 + 6);
      if_req[2] = 1'b0;
      $display("[TB] txn zero-wait fetch addr=204 rdata=%h cycle=%0d", if_rdata[2], cyc);

      repeat (4) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
